// File: rtl/port_wr_ingress_buffer.sv
// Port write ingress buffer: stores whole packets from a port and presents
// them to the SRAM side one at a time with a match handshake and a word stream.
module port_wr_ingress_buffer #(
  parameter int DEPTH = 64,
  parameter int AF_TH = 48
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_sop,
  input  logic        wr_eop,
  input  logic        wr_vld,
  input  logic [15:0] wr_data,
  input  logic        pause,
  output logic        full,
  output logic        almost_full,
  output logic        match_req,
  output logic [3:0]  new_dest_port,
  output logic [2:0]  new_prior,
  output logic [8:0]  new_length,
  input  logic        match_end,
  output logic        xfer_data_vld,
  output logic [15:0] xfer_data,
  output logic        end_of_packet,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_AF_TH = (AW+1)'(AF_TH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_MATCH, R_XFER} rd_state_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [15:0]   r_mem [DEPTH];

  wr_state_t     r_wr_state, w_wr_state_nxt;
  rd_state_t     r_rd_state, w_rd_state_nxt;
  logic [AW:0]   r_spec_ptr, r_commit_ptr, r_rd_ptr;
  logic [AW:0]   w_spec_nxt, w_commit_nxt, w_rd_nxt;
  logic [AW:0]   w_occ_base, w_occ_spec, w_occ_nxt;
  logic [AW:0]   r_pkt_cnt;
  logic [8:0]    r_wcnt, r_len, w_wcnt_nxt, w_len_nxt;
  logic [8:0]    r_xcnt, w_xcnt_nxt;
  logic          w_we;
  logic [AW-1:0] w_wa;
  logic          w_commit;
  logic [1:0]    w_drops;
  logic          w_load_hdr;
  logic          w_xvld, w_xlast;
  logic [15:0]   w_head;
  logic          r_full, r_af;
  logic [7:0]    r_drop_cnt;
  logic [3:0]    r_new_dest;
  logic [2:0]    r_new_prior;
  logic [8:0]    r_new_length;

  // Occupancy measured from the committed pointer is what a fresh packet sees,
  // because a sop always restarts at the commit point.
  assign w_occ_base = r_commit_ptr - r_rd_ptr;
  assign w_occ_spec = r_spec_ptr - r_rd_ptr;
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_spec_nxt     = r_spec_ptr;
    w_commit_nxt   = r_commit_ptr;
    w_wcnt_nxt     = r_wcnt;
    w_len_nxt      = r_len;
    w_we           = 1'b0;
    w_wa           = r_spec_ptr[AW-1:0];
    w_commit       = 1'b0;
    w_drops        = 2'd0;
    if (wr_vld) begin
      if (wr_sop && (r_wr_state != W_DROP)) begin
        if (r_wr_state == W_RECV) w_drops = 2'd1;
        w_spec_nxt = r_commit_ptr;
        if (w_occ_base == L_DEPTH) begin
          w_drops        = w_drops + 2'd1;
          w_wr_state_nxt = wr_eop ? W_IDLE : W_DROP;
        end else begin
          w_we       = 1'b1;
          w_wa       = r_commit_ptr[AW-1:0];
          w_wcnt_nxt = 9'd1;
          w_len_nxt  = wr_data[15:7];
          if (wr_eop) begin
            w_wr_state_nxt = W_IDLE;
            if (wr_data[15:7] == 9'd1) begin
              w_spec_nxt   = r_commit_ptr + PTR_ONE;
              w_commit_nxt = r_commit_ptr + PTR_ONE;
              w_commit     = 1'b1;
            end else begin
              w_drops = w_drops + 2'd1;
            end
          end else begin
            w_spec_nxt     = r_commit_ptr + PTR_ONE;
            w_wr_state_nxt = W_RECV;
          end
        end
      end else if (r_wr_state == W_RECV) begin
        if (w_occ_spec == L_DEPTH) begin
          w_drops        = 2'd1;
          w_spec_nxt     = r_commit_ptr;
          w_wr_state_nxt = wr_eop ? W_IDLE : W_DROP;
        end else begin
          w_we       = 1'b1;
          w_wcnt_nxt = r_wcnt + 9'd1;
          if (wr_eop) begin
            w_wr_state_nxt = W_IDLE;
            if (r_wcnt + 9'd1 == r_len) begin
              w_spec_nxt   = r_spec_ptr + PTR_ONE;
              w_commit_nxt = r_spec_ptr + PTR_ONE;
              w_commit     = 1'b1;
            end else begin
              w_drops    = 2'd1;
              w_spec_nxt = r_commit_ptr;
            end
          end else begin
            w_spec_nxt = r_spec_ptr + PTR_ONE;
          end
        end
      end else if ((r_wr_state == W_DROP) && wr_eop) begin
        w_wr_state_nxt = W_IDLE;
      end
    end
  end

  assign w_xvld  = (r_rd_state == R_XFER) && !pause;
  assign w_xlast = w_xvld && (r_xcnt == r_new_length - 9'd1);

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_nxt       = r_rd_ptr;
    w_xcnt_nxt     = r_xcnt;
    w_load_hdr     = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        if (r_pkt_cnt != '0) begin
          w_rd_state_nxt = R_MATCH;
          w_load_hdr     = 1'b1;
        end
      end
      R_MATCH: begin
        if (match_end) begin
          w_rd_state_nxt = R_XFER;
          w_xcnt_nxt     = 9'd0;
        end
      end
      R_XFER: begin
        if (w_xvld) begin
          w_rd_nxt   = r_rd_ptr + PTR_ONE;
          w_xcnt_nxt = r_xcnt + 9'd1;
          if (w_xlast) w_rd_state_nxt = R_IDLE;
        end
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  assign w_occ_nxt = w_spec_nxt - w_rd_nxt;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wa] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wr_state   <= W_IDLE;
      r_rd_state   <= R_IDLE;
      r_spec_ptr   <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
      r_pkt_cnt    <= '0;
      r_wcnt       <= '0;
      r_len        <= '0;
      r_xcnt       <= '0;
      r_full       <= 1'b0;
      r_af         <= 1'b0;
      r_drop_cnt   <= '0;
      r_new_dest   <= '0;
      r_new_prior  <= '0;
      r_new_length <= '0;
    end else begin
      r_wr_state   <= w_wr_state_nxt;
      r_rd_state   <= w_rd_state_nxt;
      r_spec_ptr   <= w_spec_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_rd_ptr     <= w_rd_nxt;
      r_wcnt       <= w_wcnt_nxt;
      r_len        <= w_len_nxt;
      r_xcnt       <= w_xcnt_nxt;
      r_full       <= (w_occ_nxt == L_DEPTH);
      r_af         <= (w_occ_nxt >= L_AF_TH);
      r_drop_cnt   <= sat_add8(r_drop_cnt, w_drops);
      if (w_commit && !w_xlast)      r_pkt_cnt <= r_pkt_cnt + PTR_ONE;
      else if (!w_commit && w_xlast) r_pkt_cnt <= r_pkt_cnt - PTR_ONE;
      if (w_load_hdr) begin
        r_new_dest   <= w_head[3:0];
        r_new_prior  <= w_head[6:4];
        r_new_length <= w_head[15:7];
      end
    end
  end

  assign full          = r_full;
  assign almost_full   = r_af;
  assign drop_cnt      = r_drop_cnt;
  assign match_req     = (r_rd_state == R_MATCH);
  assign new_dest_port = r_new_dest;
  assign new_prior     = r_new_prior;
  assign new_length    = r_new_length;
  assign xfer_data_vld = w_xvld;
  assign xfer_data     = w_xvld ? w_head : 16'h0000;
  assign end_of_packet = w_xlast;

endmodule

// File: tb/tb_port_wr_ingress_buffer.sv
// Directed bench for port_wr_ingress_buffer: per-cycle vectors with expected
// outputs observed during the cycle the inputs are applied.
module tb_port_wr_ingress_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_sop, wr_eop, wr_vld;
  logic [15:0] wr_data;
  logic        pause, match_end;
  logic        full, almost_full, match_req;
  logic [3:0]  new_dest_port;
  logic [2:0]  new_prior;
  logic [8:0]  new_length;
  logic        xfer_data_vld, end_of_packet;
  logic [15:0] xfer_data;
  logic [7:0]  drop_cnt;

  always #5 clk = ~clk;

  port_wr_ingress_buffer #(.DEPTH(64), .AF_TH(48)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld), .wr_data(wr_data),
    .pause(pause), .full(full), .almost_full(almost_full),
    .match_req(match_req), .new_dest_port(new_dest_port), .new_prior(new_prior),
    .new_length(new_length), .match_end(match_end),
    .xfer_data_vld(xfer_data_vld), .xfer_data(xfer_data),
    .end_of_packet(end_of_packet), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        rst, vld, sop, eop;
    logic [15:0] data;
    logic        pause, mend;
    logic        e_mreq;
    logic [3:0]  e_dest;
    logic [8:0]  e_len;
    logic        e_xvld;
    logic [15:0] e_xdata;
    logic        e_xeop;
    logic        e_full, e_af;
    logic [7:0]  e_dcnt;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;
  int vec_idx  = 0;
  vec_t tbl[$];

  function automatic vec_t mk(int vld, int sop, int eop, int d, int p, int me,
                              int mr, int dst, int ln, int xv, int xd, int xe, int dc);
    vec_t v;
    v.rst = 1'b0; v.vld = 1'(vld); v.sop = 1'(sop); v.eop = 1'(eop);
    v.data = 16'(d); v.pause = 1'(p); v.mend = 1'(me);
    v.e_mreq = 1'(mr); v.e_dest = 4'(dst); v.e_len = 9'(ln);
    v.e_xvld = 1'(xv); v.e_xdata = 16'(xd); v.e_xeop = 1'(xe);
    v.e_full = 1'b0; v.e_af = 1'b0; v.e_dcnt = 8'(dc);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: vec %0d got 0x%0h, expected 0x%0h", nm, vec_idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    rst_n = v.rst; wr_vld = v.vld; wr_sop = v.sop; wr_eop = v.eop;
    wr_data = v.data; pause = v.pause; match_end = v.mend;
    #1;
    chk("match_req", 32'(match_req), 32'(v.e_mreq));
    if (v.e_mreq) begin
      chk("new_dest_port", 32'(new_dest_port), 32'(v.e_dest));
      chk("new_length", 32'(new_length), 32'(v.e_len));
    end
    chk("xfer_data_vld", 32'(xfer_data_vld), 32'(v.e_xvld));
    if (v.e_xvld) chk("xfer_data", 32'(xfer_data), 32'(v.e_xdata));
    chk("end_of_packet", 32'(end_of_packet), 32'(v.e_xeop));
    chk("full", 32'(full), 32'(v.e_full));
    chk("almost_full", 32'(almost_full), 32'(v.e_af));
    chk("drop_cnt", 32'(drop_cnt), 32'(v.e_dcnt));
    vec_idx++;
    @(negedge clk);
  endtask

  // Drives idle inputs with reset released and checks every output is zero.
  task automatic idle_zero_check();
    rst_n = 1'b0; wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
    wr_data = 16'h0; pause = 1'b0; match_end = 1'b0;
    #1;
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_almost_full", 32'(almost_full), 32'h0);
    chk("rst_match_req", 32'(match_req), 32'h0);
    chk("rst_new_dest_port", 32'(new_dest_port), 32'h0);
    chk("rst_new_prior", 32'(new_prior), 32'h0);
    chk("rst_new_length", 32'(new_length), 32'h0);
    chk("rst_xfer_data_vld", 32'(xfer_data_vld), 32'h0);
    chk("rst_xfer_data", 32'(xfer_data), 32'h0);
    chk("rst_end_of_packet", 32'(end_of_packet), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    vec_idx++;
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b1; wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
    wr_data = 16'h0; pause = 1'b0; match_end = 1'b0;
    @(negedge clk);
    @(negedge clk);
    idle_zero_check();

    // 4-word packet, header 0x0205: dest 5, length 4
    tbl.push_back(mk(1,1,0,'h0205, 0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1,0,0,'hA001, 0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1,0,0,'hA002, 0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1,0,1,'hA003, 0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,      0,0, 1,5,4, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,      0,1, 1,5,4, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'h0205,0, 0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'hA001,0, 0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'hA002,0, 0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'hA003,1, 0));
    tbl.push_back(mk(0,0,0,0,      0,1, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 0));
    // length 4 but eop on the third word
    tbl.push_back(mk(1,1,0,'h0206, 0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1,0,0,'hB001, 0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(1,0,1,'hB002, 0,0, 0,0,0, 0,0,0, 0));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 1));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 1));
    // sop while receiving: old packet dropped, new 2-word packet kept
    tbl.push_back(mk(1,1,0,'h0209, 0,0, 0,0,0, 0,0,0, 1));
    tbl.push_back(mk(1,0,0,'hC0DE, 0,0, 0,0,0, 0,0,0, 1));
    tbl.push_back(mk(1,1,0,'h010A, 0,0, 0,0,0, 0,0,0, 1));
    tbl.push_back(mk(1,0,1,'hD00D, 0,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,1, 1,10,2, 0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'h010A,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'hD00D,1, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 2));
    // 5-word packet with a 3-cycle pause after the header
    tbl.push_back(mk(1,1,0,'h0283, 0,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(1,0,0,'hC001, 0,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(1,0,0,'hC002, 0,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(1,0,0,'hC003, 0,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(1,0,1,'hC004, 0,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,1, 1,3,5, 0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'h0283,0, 2));
    tbl.push_back(mk(0,0,0,0,      1,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,      1,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,      1,0, 0,0,0, 0,0,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'hC001,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'hC002,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'hC003,0, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 1,'hC004,1, 2));
    tbl.push_back(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 2));
    foreach (tbl[i]) apply(tbl[i]);

    // 70-word packet (header 0x2301, length 70) into 64 words
    for (int i = 0; i < 70; i++) begin
      v = mk(1, int'(i == 0), int'(i == 69), (i == 0) ? 'h2301 : ('h3000 + i),
             0,0, 0,0,0, 0,0,0, (i >= 65) ? 3 : 2);
      v.e_full = (i == 64);
      v.e_af   = (i >= 48) && (i <= 64);
      apply(v);
    end
    apply(mk(1,1,0,'h0107, 0,0, 0,0,0, 0,0,0, 3));
    apply(mk(1,0,1,'hD001, 0,0, 0,0,0, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,1, 1,7,2, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 1,'h0107,0, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 1,'hD001,1, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 3));

    // B commits in the same cycle as A's last transferred word
    apply(mk(1,1,0,'h0182, 0,0, 0,0,0, 0,0,0, 3));
    apply(mk(1,0,0,'hE001, 0,0, 0,0,0, 0,0,0, 3));
    apply(mk(1,0,1,'hE002, 0,0, 0,0,0, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,1, 1,2,3, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 1,'h0182,0, 3));
    apply(mk(1,1,0,'h0108, 0,0, 0,0,0, 1,'hE001,0, 3));
    apply(mk(1,0,1,'hF001, 0,0, 0,0,0, 1,'hE002,1, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,1, 1,8,2, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 1,'h0108,0, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 1,'hF001,1, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 3));
    apply(mk(0,0,0,0,      0,0, 0,0,0, 0,0,0, 3));

    // Reset while receiving a third packet with two packets buffered
    apply(mk(1,1,0,'h0101, 0,0, 0,0,0, 0,0,0, 3));
    apply(mk(1,0,1,'h1111, 0,0, 0,0,0, 0,0,0, 3));
    apply(mk(1,1,0,'h0102, 0,0, 0,0,0, 0,0,0, 3));
    apply(mk(1,0,1,'h2222, 0,0, 1,1,2, 0,0,0, 3));
    apply(mk(1,1,0,'h0203, 0,0, 1,1,2, 0,0,0, 3));
    apply(mk(1,0,0,'h3333, 0,0, 1,1,2, 0,0,0, 3));
    v = mk(0,0,0,0, 0,0, 1,1,2, 0,0,0, 3);
    v.rst = 1'b1;
    apply(v);
    idle_zero_check();
    apply(mk(1,0,1,'h4444, 0,0, 0,0,0, 0,0,0, 0));
    for (int k = 0; k < 6; k++) apply(mk(0,0,0,0, 0,k % 2, 0,0,0, 0,0,0, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
